// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : motor_pkg
//  Purpose  : Shared definitions for the stepper coil phase decoder.
//             Holds the eight legal coil phase codes, the code-to-index
//             decoder and the lock state enumeration.
//  Revision : 1.0  initial release
// ============================================================================
package motor_pkg;

    // Legal coil patterns in sequence order. The index rises by one per
    // forward half step.
    localparam logic [3:0] PH_A  = 4'b1000;  // index 0
    localparam logic [3:0] PH_AB = 4'b1010;  // index 1
    localparam logic [3:0] PH_B  = 4'b0010;  // index 2
    localparam logic [3:0] PH_BC = 4'b0110;  // index 3
    localparam logic [3:0] PH_C  = 4'b0100;  // index 4
    localparam logic [3:0] PH_CD = 4'b0101;  // index 5
    localparam logic [3:0] PH_D  = 4'b0001;  // index 6
    localparam logic [3:0] PH_DA = 4'b1001;  // index 7

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Returns {legal, idx[2:0]}. Illegal codes return legal=0, idx=0.
    function automatic logic [3:0] phase_to_idx(input logic [3:0] code);
        logic [3:0] res;
        case (code)
            PH_A:    res = 4'b1_000;
            PH_AB:   res = 4'b1_001;
            PH_B:    res = 4'b1_010;
            PH_BC:   res = 4'b1_011;
            PH_C:    res = 4'b1_100;
            PH_CD:   res = 4'b1_101;
            PH_D:    res = 4'b1_110;
            PH_DA:   res = 4'b1_111;
            default: res = 4'b0_000;
        endcase
        return res;
    endfunction

endpackage : motor_pkg
`default_nettype wire

// File: rtl/phase_filter.sv
`default_nettype none
// ============================================================================
//  Module   : phase_filter
//  Purpose  : Registers the raw coil pattern and accepts a new value only
//             after it has been stable for FILT_CYCLES consecutive cycles.
//  Ports    : clk       in   system clock
//             rst       in   synchronous active-high reset
//             phase_i   in   raw coil pattern
//             accept_o  out  one-cycle strobe: pattern_o is being accepted
//             pattern_o out  pattern under evaluation (valid with accept_o)
//  Revision : 1.0  initial release
// ============================================================================
module phase_filter #(
    parameter int FILT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phase_i,
    output logic       accept_o,
    output logic [3:0] pattern_o
);

    localparam logic [3:0] c_FILT = 4'(FILT_CYCLES);

    logic [3:0] in_q;
    logic [3:0] cand_q, cand_d;
    logic [3:0] acc_q,  acc_d;
    logic [3:0] cnt_q,  cnt_d;
    logic [3:0] w_cnt_next;
    logic       w_accept;

    always_comb begin
        cand_d     = cand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        w_cnt_next = 4'd1;
        w_accept   = 1'b0;
        if (in_q == acc_q) begin
            // Value fell back to the accepted pattern: abandon any run.
            cnt_d = 4'd0;
        end else begin
            // A zero count means no run in progress, so restart at 1 even
            // if the stale candidate happens to match.
            if ((cnt_q != 4'd0) && (in_q == cand_q)) begin
                w_cnt_next = cnt_q + 4'd1;
            end
            cand_d = in_q;
            if (w_cnt_next == c_FILT) begin
                w_accept = 1'b1;
                acc_d    = in_q;
                cnt_d    = 4'd0;
            end else begin
                cnt_d = w_cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= 4'd0;
            cand_q <= 4'd0;
            acc_q  <= 4'd0;
            cnt_q  <= 4'd0;
        end else begin
            in_q   <= phase_i;
            cand_q <= cand_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    // The strobe is combinational so the consumer registers the event on
    // the same edge the filter commits the new pattern.
    assign accept_o  = w_accept;
    assign pattern_o = in_q;

endmodule : phase_filter
`default_nettype wire

// File: rtl/phase_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : phase_decoder
//  Purpose  : Closed-loop checker and position tracker for a stepper phase
//             sequencer. Decodes filtered coil transitions into half/full
//             step events, tracks signed position in half steps and flags
//             illegal patterns and skipped steps.
//  Ports    : clk          in   system clock
//             rst          in   synchronous active-high reset
//             clr          in   clear position and error state
//             phase_in     in   coil pattern [3:0]
//             pos          out  signed position, half-step units
//             step_pulse   out  one-cycle strobe per decoded step
//             step_dir     out  direction of last step (1 = forward)
//             step_half    out  size of last step (1 = half step)
//             valid_phase  out  high while locked
//             err_illegal  out  sticky illegal-pattern flag
//             err_skip     out  sticky skipped-step flag
//             err_cnt      out  saturating error event count
//  Revision : 1.0  initial release
// ============================================================================
module phase_decoder
    import motor_pkg::*;
#(
    parameter int FILT_CYCLES = 4,
    parameter int POS_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [3:0]              phase_in,
    output logic signed [POS_W-1:0] pos,
    output logic                    step_pulse,
    output logic                    step_dir,
    output logic                    step_half,
    output logic                    valid_phase,
    output logic                    err_illegal,
    output logic                    err_skip,
    output logic [7:0]              err_cnt
);

    localparam logic [POS_W-1:0] c_PLUS1  = POS_W'(1);
    localparam logic [POS_W-1:0] c_PLUS2  = POS_W'(2);
    localparam logic [POS_W-1:0] c_MINUS1 = {POS_W{1'b1}};
    localparam logic [POS_W-1:0] c_MINUS2 = {{(POS_W-1){1'b1}}, 1'b0};

    logic       w_accept;
    logic [3:0] w_pattern;

    phase_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .phase_i   (phase_in),
        .accept_o  (w_accept),
        .pattern_o (w_pattern)
    );

    lock_state_e      state_q, state_d;
    logic [2:0]       ref_q,   ref_d;
    logic [POS_W-1:0] pos_q,   pos_d;
    logic             dir_q,   dir_d;
    logic             half_q,  half_d;
    logic             pulse_q, pulse_d;
    logic             eill_q,  eill_d;
    logic             eskip_q, eskip_d;
    logic [7:0]       ecnt_q,  ecnt_d;

    logic [3:0]       w_dec;
    logic             w_legal;
    logic [2:0]       w_idx;
    logic [2:0]       w_delta;
    logic             w_step_ev;
    logic             w_ill_ev;
    logic             w_skip_ev;
    logic [POS_W-1:0] w_step_amt;
    logic             w_step_dir;
    logic             w_step_half;

    assign w_dec   = phase_to_idx(w_pattern);
    assign w_legal = w_dec[3];
    assign w_idx   = w_dec[2:0];
    // 3-bit subtraction gives (idx - ref) mod 8 directly.
    assign w_delta = w_idx - ref_q;

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        w_step_ev   = 1'b0;
        w_ill_ev    = 1'b0;
        w_skip_ev   = 1'b0;
        w_step_amt  = '0;
        w_step_dir  = 1'b0;
        w_step_half = 1'b0;
        if (w_accept) begin
            case (state_q)
                UNLOCKED: begin
                    if (w_legal) begin
                        state_d = LOCKED;
                        ref_d   = w_idx;
                    end else begin
                        w_ill_ev = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_legal) begin
                        w_ill_ev = 1'b1;
                        state_d  = UNLOCKED;
                    end else begin
                        ref_d = w_idx;
                        case (w_delta)
                            3'd1: begin
                                w_step_ev = 1'b1; w_step_amt = c_PLUS1;
                                w_step_dir = 1'b1; w_step_half = 1'b1;
                            end
                            3'd2: begin
                                w_step_ev = 1'b1; w_step_amt = c_PLUS2;
                                w_step_dir = 1'b1; w_step_half = 1'b0;
                            end
                            3'd7: begin
                                w_step_ev = 1'b1; w_step_amt = c_MINUS1;
                                w_step_dir = 1'b0; w_step_half = 1'b1;
                            end
                            3'd6: begin
                                w_step_ev = 1'b1; w_step_amt = c_MINUS2;
                                w_step_dir = 1'b0; w_step_half = 1'b0;
                            end
                            // 3..5 are lost steps; 0 cannot occur because an
                            // accepted pattern always differs from the last.
                            default: w_skip_ev = 1'b1;
                        endcase
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // Event application. clr takes priority and swallows any event this
    // cycle; lock tracking above still follows the pattern.
    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        half_d  = half_q;
        pulse_d = 1'b0;
        eill_d  = eill_q;
        eskip_d = eskip_q;
        ecnt_d  = ecnt_q;
        if (clr) begin
            pos_d   = '0;
            eill_d  = 1'b0;
            eskip_d = 1'b0;
            ecnt_d  = 8'd0;
        end else begin
            if (w_step_ev) begin
                pos_d   = pos_q + w_step_amt;
                dir_d   = w_step_dir;
                half_d  = w_step_half;
                pulse_d = 1'b1;
            end
            if (w_ill_ev) begin
                eill_d = 1'b1;
            end
            if (w_skip_ev) begin
                eskip_d = 1'b1;
            end
            if ((w_ill_ev || w_skip_ev) && (ecnt_q != 8'hFF)) begin
                ecnt_d = ecnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            ref_q   <= 3'd0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            pulse_q <= 1'b0;
            eill_q  <= 1'b0;
            eskip_q <= 1'b0;
            ecnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            pulse_q <= pulse_d;
            eill_q  <= eill_d;
            eskip_q <= eskip_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign pos         = pos_q;
    assign step_pulse  = pulse_q;
    assign step_dir    = dir_q;
    assign step_half   = half_q;
    assign valid_phase = (state_q == LOCKED);
    assign err_illegal = eill_q;
    assign err_skip    = eskip_q;
    assign err_cnt     = ecnt_q;

endmodule : phase_decoder
`default_nettype wire
